load_store_unit: RTL and testbench

Initiator side of the byte-addressable data memory interface. It accepts one load or store request at a time from the datapath and converts it into `memread`/`memwrite` transactions on the data memory. Sub-word stores are performed as read-modify-write, because the memory always writes four bytes. Loads return sign- or zero-extended data. Memory byte order is big-endian: the byte at `addr` is bits [31:24] of the word.

---
 rtl/load_store_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a big-endian, byte-addressable data
// memory. One load or store is in flight at a time. Sub-word stores are done
// as read-modify-write because the memory always writes a full word.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests complete with resp_err and no memory access; when
// undefined they are silently aligned down to their natural boundary.
//
// Handshake: a request transfers on the posedge where req_valid && req_ready;
// req_ready is high only in IDLE, and the req_* fields are sampled only on
// that edge. resp_valid is a one-cycle completion pulse with no back-pressure;
// resp_rdata/resp_err are meaningful only while it is high.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q,      state_d;
  logic        store_q,      store_d;
  logic [1:0]  size_q,       size_d;
  logic        unsigned_q,   unsigned_d;
  logic [1:0]  off_q,        off_d;
  logic [31:0] wdata_q,      wdata_d;
  logic [31:0] buf_q,        buf_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic        mem_read_q,   mem_read_d;
  logic        mem_write_q,  mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q,   resp_err_d;
  logic        req_ready_q,  req_ready_d;

  logic        accept;
  logic [1:0]  req_off;
  logic [31:0] req_waddr;
  logic [1:0]  eff_off;
  logic        req_err;

  // Pull the addressed byte/half out of a big-endian word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lanes of a big-endian word with right-justified data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = data[7:0];
          2'd1:    r[23:16] = data[7:0];
          2'd2:    r[15:8]  = data[7:0];
          default: r[7:0]   = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = data[15:0];
        else        r[31:16] = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  // Decode the incoming request: word address, effective lane offset, error.
  always_comb begin
    accept    = req_valid && req_ready_q;
    req_off   = req_addr[1:0];
    req_waddr = {req_addr[31:2], 2'b00};
    // Halves align down to the nearest even lane pair, words to lane 0.
    case (req_size)
      2'b00:   eff_off = req_off;
      2'b01:   eff_off = {req_off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    req_err = (req_size == 2'b11) || (req_waddr >= MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01) && req_off[0]) req_err = 1'b1;
    if ((req_size == 2'b10) && (req_off != 2'b00)) req_err = 1'b1;
`endif
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    req_ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          store_d     = req_store;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          off_d       = eff_off;
          wdata_d     = req_wdata;
          mem_addr_d  = req_waddr;
          if (req_err) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_store && (req_size == 2'b10)) begin
            // Full-word store needs no read.
            state_d     = S_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = S_RD;
            mem_read_d = 1'b1;
          end
        end
      end

      S_RD: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        // mem_rdata has been updated by the read strobe; take it now.
        buf_d = mem_rdata;
        if (store_q) begin
          state_d     = S_WR;
          mem_write_d = 1'b1;
          mem_wdata_d = merge_lane(mem_rdata, wdata_q, size_q, off_q);
        end else begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = extract_lane(mem_rdata, size_q, off_q, unsigned_q);
        end
      end

      S_WR: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
      end

      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      buf_q        <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench for load_store_unit with a
// byte-array memory model and a scoreboard of expected responses.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  // {expected response cycle[31:0], err, rdata[31:0]}
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [7:0]  mem [0:127];

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int i;
    i = int'(a[6:0]) & 124;
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  // Memory model: read data updates on posedge with mem_read, write at negedge.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem_rdata = 32'h0;
    forever begin
      @(clk);
      if (clk === 1'b1) begin
        if (mem_read === 1'b1 && mem_addr < 32'd128) mem_rdata <= mem_word(mem_addr);
      end else if (mem_write === 1'b1 && mem_addr < 32'd128) begin
        mem[int'(mem_addr[6:0])]     = mem_wdata[31:24];
        mem[int'(mem_addr[6:0]) + 1] = mem_wdata[23:16];
        mem[int'(mem_addr[6:0]) + 2] = mem_wdata[15:8];
        mem[int'(mem_addr[6:0]) + 3] = mem_wdata[7:0];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: strobe counting and response comparison.
  always @(negedge clk) begin
    if (mem_read === 1'b1) rd_cnt <= rd_cnt + 1;
    if (mem_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: actual=both high required=one at most (cycle %0d)", cyc);
    end
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: actual resp_valid=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(mon_e[64:33]));
        chk("resp_err", 64'(resp_err), 64'(mon_e[32]));
        chk("resp_rdata", 64'(resp_rdata), 64'(mon_e[31:0]));
      end
    end
  end

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic un,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic err, input logic [31:0] rd);
    vec_t v;
    v.st = st; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"},  64'(req_ready),  64'd1);
    chk({name, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({name, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({name, "_resp_err"},   64'(resp_err),   64'd0);
    chk({name, "_mem_read"},   64'(mem_read),   64'd0);
    chk({name, "_mem_write"},  64'(mem_write),  64'd0);
    chk({name, "_mem_addr"},   64'(mem_addr),   64'd0);
    chk({name, "_mem_wdata"},  64'(mem_wdata),  64'd0);
  endtask

  task automatic wait_ready(input string name, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: actual req_ready=%b required=1", name, req_ready);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_store    = v.st;
    req_size     = v.sz;
    req_unsigned = v.un;
    req_addr     = v.addr;
    req_wdata    = v.wd;
  endtask

  // Junk on the request fields after accept must be ignored.
  task automatic scramble;
    req_valid    = 1'b0;
    req_store    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Driver: one request, scoreboard push, wait for drain, check strobe counts.
  task automatic do_req(input vec_t v, input string name);
    int lat, nrd, nwr, rd0, wr0, acc;
    bit got;
    if (v.err)             begin lat = 1; nrd = 0; nwr = 0; end
    else if (!v.st)        begin lat = 3; nrd = 1; nwr = 0; end
    else if (v.sz == 2'b10) begin lat = 2; nrd = 0; nwr = 1; end
    else                   begin lat = 4; nrd = 1; nwr = 1; end
    wait_ready(name, got);
    if (!got) return;
    drive(v);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back({32'(acc + lat - 1), v.err, v.rd});
    scramble();
    chk({name, "_mem_addr"}, 64'(mem_addr), 64'({v.addr[31:2], 2'b00}));
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_resp_timeout: actual no resp_valid required resp within %0d cycles", name, lat);
      exp_q.delete();
    end
    chk({name, "_reads"},  64'(rd_cnt - rd0), 64'(nrd));
    chk({name, "_writes"}, 64'(wr_cnt - wr0), 64'(nwr));
  endtask

  // Reset in the CAP cycle: no write, no response, outputs cleared.
  task automatic abort_in_cap(input vec_t v, input string name);
    int wr0;
    bit got;
    wait_ready(name, got);
    if (!got) return;
    drive(v);
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    scramble();
    @(posedge clk);
    #1;
    chk({name, "_in_cap"}, 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs({name, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk({name, "_writes"}, 64'(wr_cnt - wr0), 64'd0);
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int n;
    int acc[3];
    bit got;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    // Vector table: st, size, unsigned, addr, wdata, err, rdata
    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h11, 32'hA5A5A580, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11803344));
    tbl.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0, 0, 32'hFFFFFF80));
    tbl.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0, 0, 32'h00000080));
    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h12, 32'h5555ABCD, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1122ABCD));
    tbl.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'hFFFFABCD));
    tbl.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 0, 32'h0000ABCD));
    tbl.push_back(mk(0, 2'b00, 1, 32'h10, 32'h0, 0, 32'h00000011));
    tbl.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFFCD));
    tbl.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h00001122));
    tbl.push_back(mk(1, 2'b00, 0, 32'h13, 32'h000000FE, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1122ABFE));
    tbl.push_back(mk(1, 2'b00, 0, 32'h10, 32'h00000077, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h7722ABFE));
    tbl.push_back(mk(0, 2'b10, 0, 32'h13, 32'h0, TRAP, TRAP ? 32'h0 : 32'h7722ABFE));
    tbl.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, TRAP, TRAP ? 32'h0 : 32'hFFFFABFE));
    tbl.push_back(mk(1, 2'b01, 0, 32'h13, 32'h00001234, TRAP, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, TRAP ? 32'h7722ABFE : 32'h77221234));
    tbl.push_back(mk(0, 2'b10, 0, 32'h80, 32'h0, 1, 32'h0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h81, 32'h0, 1, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h7C, 32'h0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(0, 2'b00, 0, 32'h7C, 32'h0, 0, 32'hFFFFFFCA));
    tbl.push_back(mk(0, 2'b00, 1, 32'h7F, 32'h0, 0, 32'h0000000D));
    tbl.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0));
    tbl.push_back(mk(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h80, 32'h000000AA, 1, 32'h0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h22, 32'h99887766, TRAP, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, TRAP ? 32'h0 : 32'h99887766));
    tbl.push_back(mk(1, 2'b10, 0, 32'h20, 32'h01020304, 0, 32'h0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h01020304));

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Word store then word load; check big-endian byte placement.
    do_req(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0), "sw_deadbeef");
    chk("mem_10", 64'(mem[16]), 64'hDE);
    chk("mem_11", 64'(mem[17]), 64'hAD);
    chk("mem_12", 64'(mem[18]), 64'hBE);
    chk("mem_13", 64'(mem[19]), 64'hEF);
    do_req(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF), "lw_deadbeef");

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i], $sformatf("vec%0d", i));
    end
    chk("mem_word_10", 64'(mem_word(32'h10)), TRAP ? 64'h7722ABFE : 64'h77221234);

    // Back-to-back word stores with req_valid held high: one per 3 cycles.
    n = 0;
    for (int g = 0; g < 30 && n < 3; g++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        drive(mk(1, 2'b10, 0, 32'h40 + 32'(4 * n), 32'hA0A00000 + 32'(n), 0, 32'h0));
        @(posedge clk);
        #1;
        acc[n] = cyc;
        exp_q.push_back({32'(cyc + 1), 1'b0, 32'h0});
        n++;
      end
    end
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL b2b_resp_timeout: actual %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    chk("b2b_accepts", 64'(n), 64'd3);
    chk("b2b_gap0", 64'(acc[1] - acc[0]), 64'd3);
    chk("b2b_gap1", 64'(acc[2] - acc[1]), 64'd3);
    chk("b2b_mem40", 64'(mem_word(32'h40)), 64'hA0A00000);
    chk("b2b_mem48", 64'(mem_word(32'h48)), 64'hA0A00002);

    // Reset during CAP of a byte store and of a load.
    abort_in_cap(mk(1, 2'b00, 0, 32'h20, 32'h000000FF, 0, 32'h0), "abort_sb");
    chk("abort_mem20", 64'(mem_word(32'h20)), 64'h01020304);
    abort_in_cap(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h0), "abort_lw");
    do_req(mk(0, 2'b00, 1, 32'h23, 32'h0, 0, 32'h00000004), "lbu_after_abort");

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
